// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and hold-until-release ownership.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [2:0] idx_nxt;
    logic       valid_nxt;
    logic       timeout_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       hold_expired;
    logic [3:0] pick;

    // Returns {hit, index}: first requester strictly after p, wrapping, with p itself last.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic       hit;
        logic [2:0] win;
        logic [2:0] cand;
        hit = 1'b0;
        win = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = p + 3'(k);
            if (!hit && r[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
        return {hit, win};
    endfunction

    assign pick = rr_pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Counter value n means the owner is in its (n+1)-th grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (cnt_clr) begin
            hold_cnt <= '0;
        end else if (cnt_inc && (hold_cnt != {CNT_W{1'b1}})) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_expired = (hold_cnt >= HOLD_LAST);
`else
    logic [CNT_W-1:0] hold_cfg_unused;
    logic             ctl_unused;

    assign hold_cfg_unused = CNT_W'(MAX_HOLD);
    assign ctl_unused      = cnt_clr ^ cnt_inc;
    assign hold_expired    = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (pick[3]) begin
                    idx_nxt   = pick[2:0];
                    valid_nxt = 1'b1;
                    ptr_nxt   = pick[2:0];
                    cnt_clr   = 1'b1;
                    state_nxt = GRANT;
                end else begin
                    idx_nxt   = 3'd0;
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    idx_nxt   = 3'd0;
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (hold_expired) begin
                    // Revoked owner keeps ptr so it is searched last next time.
                    idx_nxt     = 3'd0;
                    valid_nxt   = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                idx_nxt   = 3'd0;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= valid_nxt ? (8'h01 << idx_nxt) : 8'h00;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a cycle-level ownership model queues expected outputs,
// a monitor pops and compares one entry per clock.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    // Model state: owner = -1 means nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 7;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, advanced once per rising edge.
    initial begin
        exp_t e;
        int   cand;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1;
                m_ptr   = 7;
                m_held  = 0;
                m_tmo   = 1'b0;
            end else if (m_owner < 0) begin
                m_tmo = 1'b0;
                for (int k = 1; k <= 8; k++) begin
                    cand = (m_ptr + k) % 8;
                    if (m_owner < 0 && req[cand]) m_owner = cand;
                end
                if (m_owner >= 0) begin
                    m_ptr  = m_owner;
                    m_held = 1;
                end
            end else begin
                m_tmo = 1'b0;
                if (!req[m_owner]) begin
                    m_owner = -1;
`ifdef ARB_TIMEOUT_EN
                end else if (m_held >= MAX_HOLD) begin
                    m_owner = -1;
                    m_tmo   = 1'b1;
`endif
                end else begin
                    m_held = m_held + 1;
                end
            end
            e.gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
            e.idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            e.vld = (m_owner >= 0);
            e.tmo = m_tmo;
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cycle, act, want);
        end
    endtask

    // Monitor: the DUT presents a registered result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty cycle=%0d got=0 want=1", cycle);
            end else begin
                e = exp_q.pop_front();
                chk("gnt", gnt, e.gnt);
                chk("gnt_idx", {5'd0, gnt_idx}, {5'd0, e.idx});
                chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.vld});
                chk("timeout", {7'd0, timeout}, {7'd0, e.tmo});
            end
        end
    end

    task automatic drive(input logic [7:0] r, input logic rr, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = r;
            rst = rr;
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] hold_req;
        rst = 1'b1;
        req = 8'h00;
        drive(8'h00, 1'b1, 2);

        // Single requester grant and release.
        drive(8'h01, 1'b0, 3);
        drive(8'h00, 1'b0, 2);

        // All requesting; each owner drops its bit for one cycle once granted.
        drive(8'h00, 1'b1, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rst = 1'b0;
            req = (m_owner >= 0) ? (8'hFF & ~8'(1 << m_owner)) : 8'hFF;
        end

        // Sparse requesters with wrap-around.
        drive(8'h00, 1'b1, 1);
        drive(8'h90, 1'b0, 2);
        drive(8'h80, 1'b0, 3);
        drive(8'h10, 1'b0, 3);
        drive(8'h00, 1'b0, 1);

        // Long hold by a single owner (revoked only when the hold limit is built in).
        drive(8'h03, 1'b0, 100);
        drive(8'h00, 1'b0, 2);

        // Reset while idx 5 owns the grant, request still high.
        drive(8'h20, 1'b0, 3);
        drive(8'h20, 1'b1, 1);
        drive(8'h20, 1'b0, 3);
        drive(8'h00, 1'b0, 1);

        // Random traffic: owners mostly keep requesting, occasional resets.
        hold_req = 8'h00;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) hold_req = 8'($urandom);
            r = hold_req;
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) r[m_owner] = 1'b0;
            req = r;
            rst = ($urandom_range(0, 63) == 0);
        end

        drive(8'h00, 1'b0, 3);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
